vram_tile_filler: RTL and testbench

- Command-driven fill engine that writes 32-bit colour words into the tile VRAM read by the VGA controller.
- Grid is 80 columns x 60 rows of 8x8-pixel cells; there are two frames:
  - frame 0 (maze) at base 2048;
  - frame 1 (win screen) at base 6848.
- Accepts a rectangle command over a valid/ready handshake and drives the BRAM write port (port A) with one cell write per clock, in raster order.
- Sits upstream of the VGA controller; the CPU/maze logic issues the commands.

---
 rtl/vram_pkg.sv | 27 ++
 rtl/vram_tile_iter.sv | 89 ++++++++
 rtl/vram_tile_filler.sv | 126 ++++++++++++
 tb/tb_vram_tile_filler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared tile-VRAM constants, fill FSM state type and the shift-add tile address
// helper used by both the fill engine and the VGA controller.
package vram_pkg;

    localparam logic [6:0]  COLS  = 7'd80;
    localparam logic [5:0]  ROWS  = 6'd60;
    localparam logic [13:0] BASE0 = 14'd2048;
    localparam logic [13:0] BASE1 = 14'd6848;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FIN  = 2'd2
    } fill_state_t;

    // y*80 as (y<<6)+(y<<4); the largest result (6848+4799) still fits 14 bits
    function automatic logic [13:0] tile_addr(input logic       frame,
                                              input logic [6:0] x,
                                              input logic [5:0] y);
        logic [13:0] base;
        logic [13:0] yy;
        base = frame ? BASE1 : BASE0;
        yy   = {8'd0, y};
        return base + (yy << 6) + (yy << 4) + {7'd0, x};
    endfunction

endpackage

// File: rtl/vram_tile_iter.sv
// Raster x/y cell counter for the fill engine: clips the rectangle at load time,
// walks it row by row and flags the final cell.
module vram_tile_iter
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       advance_i,
    input  logic [6:0] x0_i,
    input  logic [5:0] y0_i,
    input  logic [6:0] w_i,
    input  logic [5:0] h_i,
    input  logic       border_i,
    output logic [6:0] nxt_x_o,
    output logic [5:0] nxt_y_o,
    output logic       last_o
);

    logic [6:0] x0_q, x0_d, x_last_q, x_last_d, cur_x_q, cur_x_d;
    logic [5:0] y0_q, y0_d, y_last_q, y_last_d, cur_y_q, cur_y_d;
    logic       border_q, border_d;
    logic [7:0] x_end, y_end;
    logic [6:0] x_last_clip;
    logic [5:0] y_last_clip;
    logic       interior_row;

    // 8-bit sums cannot wrap, so the clip compare is exact
    assign x_end       = {1'b0, x0_i} + {1'b0, w_i};
    assign y_end       = {2'b0, y0_i} + {2'b0, h_i};
    assign x_last_clip = (x_end > {1'b0, COLS}) ? (COLS - 7'd1) : (x_end[6:0] - 7'd1);
    assign y_last_clip = (y_end > {2'b0, ROWS}) ? (ROWS - 6'd1) : (y_end[5:0] - 6'd1);

    assign interior_row = border_q && (cur_y_q != y0_q) && (cur_y_q != y_last_q);

    always_comb begin
        x0_d     = x0_q;
        y0_d     = y0_q;
        x_last_d = x_last_q;
        y_last_d = y_last_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        border_d = border_q;
        if (load_i) begin
            x0_d     = x0_i;
            y0_d     = y0_i;
            x_last_d = x_last_clip;
            y_last_d = y_last_clip;
            cur_x_d  = x0_i;
            cur_y_d  = y0_i;
            border_d = border_i;
        end else if (advance_i) begin
            if (cur_x_q == x_last_q) begin
                cur_x_d = x0_q;
                cur_y_d = cur_y_q + 6'd1;
            end else if (interior_row && (cur_x_q == x0_q)) begin
                cur_x_d = x_last_q;
            end else begin
                cur_x_d = cur_x_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q     <= '0;
            y0_q     <= '0;
            x_last_q <= '0;
            y_last_q <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            border_q <= 1'b0;
        end else begin
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x_last_q <= x_last_d;
            y_last_q <= y_last_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            border_q <= border_d;
        end
    end

    // The next position feeds the registered address so the write lines up with the cell
    assign nxt_x_o = cur_x_d;
    assign nxt_y_o = cur_y_d;
    assign last_o  = (cur_x_q == x_last_q) && (cur_y_q == y_last_q);

endmodule

// File: rtl/vram_tile_filler.sv
// Rectangle fill engine for the tile VRAM: one cell write per clock on BRAM port A.
// Define VRAM_FILL_BORDER_EN to add cmd_border (write only the rectangle perimeter).
module vram_tile_filler
    import vram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_frame,
    input  logic [6:0]  cmd_x0,
    input  logic [5:0]  cmd_y0,
    input  logic [6:0]  cmd_w,
    input  logic [5:0]  cmd_h,
    input  logic [31:0] cmd_color,
`ifdef VRAM_FILL_BORDER_EN
    input  logic        cmd_border,
`endif
    output logic        wea,
    output logic [13:0] addra,
    output logic [31:0] dina,
    output logic        busy,
    output logic        done,
    output logic        cmd_err
);

    fill_state_t state_q;
    logic        frame_q;
    logic        cmd_ready_q, wea_q, busy_q, done_q, err_q;
    logic [13:0] addra_q;
    logic [31:0] dina_q;

    logic        accept, cmd_bad, load, advance, border, last;
    logic [6:0]  nxt_x;
    logic [5:0]  nxt_y;

`ifdef VRAM_FILL_BORDER_EN
    assign border = cmd_border;
`else
    assign border = 1'b0;
`endif

    assign accept  = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
    assign cmd_bad = (cmd_x0 >= COLS) || (cmd_y0 >= ROWS) || (cmd_w == 7'd0) || (cmd_h == 6'd0);
    assign load    = accept && !cmd_bad;
    assign advance = (state_q == ST_FILL) && !last;

    vram_tile_iter u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .advance_i (advance),
        .x0_i      (cmd_x0),
        .y0_i      (cmd_y0),
        .w_i       (cmd_w),
        .h_i       (cmd_h),
        .border_i  (border),
        .nxt_x_o   (nxt_x),
        .nxt_y_o   (nxt_y),
        .last_o    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dina_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_FILL;
                            frame_q     <= cmd_frame;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            wea_q       <= 1'b1;
                            addra_q     <= tile_addr(cmd_frame, nxt_x, nxt_y);
                            dina_q      <= cmd_color;
                        end
                    end
                end
                ST_FILL: begin
                    // The cell on the outputs now is the last one: this edge retires it
                    if (last) begin
                        state_q <= ST_FIN;
                        wea_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        addra_q <= tile_addr(frame_q, nxt_x, nxt_y);
                    end
                end
                ST_FIN: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    wea_q       <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_vram_tile_filler.sv
// Self-checking bench for vram_tile_filler: per-cycle compare against a rectangle model,
// directed cases with literal addresses, reset abort and randomized commands.
module tb_vram_tile_filler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_frame = 1'b0;
    logic [6:0]  cmd_x0 = '0;
    logic [5:0]  cmd_y0 = '0;
    logic [6:0]  cmd_w = '0;
    logic [5:0]  cmd_h = '0;
    logic [31:0] cmd_color = '0;
`ifdef VRAM_FILL_BORDER_EN
    logic        cmd_border = 1'b0;
`endif
    logic        wea;
    logic [13:0] addra;
    logic [31:0] dina;
    logic        busy, done, cmd_err;

    always #5 clk = ~clk;

    vram_tile_filler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_frame (cmd_frame),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
`ifdef VRAM_FILL_BORDER_EN
        .cmd_border(cmd_border),
`endif
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    typedef struct packed {
        logic        wea;
        logic [13:0] addra;
        logic [31:0] dina;
        logic        busy;
        logic        done;
        logic        err;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc_cnt = 0;
    int   cyc = 0;
    int   acc_cyc[$];
    int   wr_log[$];

    function automatic exp_t mk(logic w, int a, logic [31:0] d, logic b, logic dn, logic e, logic r);
        exp_t x;
        x.wea = w; x.addra = 14'(a); x.dina = d;
        x.busy = b; x.done = dn; x.err = e; x.ready = r;
        return x;
    endfunction

    // Cells of the clipped rectangle in raster order; empty list means the command is rejected
    task automatic make_plan(input bit fr, input int x0, input int y0, input int w, input int h,
                             input bit brd, output int q[$]);
        int xl, yl, base;
        q.delete();
        if (x0 >= 80 || y0 >= 60 || w == 0 || h == 0) return;
        xl   = ((x0 + w < 80) ? x0 + w : 80) - 1;
        yl   = ((y0 + h < 60) ? y0 + h : 60) - 1;
        base = fr ? 6848 : 2048;
        for (int y = y0; y <= yl; y++)
            for (int x = x0; x <= xl; x++)
                if (!brd || y == y0 || y == yl || x == x0 || x == xl)
                    q.push_back(base + y * 80 + x);
    endtask

    // Model: on each accepted handshake queue the cycles the outputs must show
    always @(posedge clk) begin
        int  cells[$];
        bit  brd;
        cyc++;
        brd = 1'b0;
`ifdef VRAM_FILL_BORDER_EN
        brd = cmd_border;
`endif
        if (rst_n && cmd_valid && cur_exp.ready) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
            make_plan(cmd_frame, int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h), brd, cells);
            if (cells.size() == 0) begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
            end else begin
                foreach (cells[i]) exp_q.push_back(mk(1, cells[i], cmd_color, 1, 0, 0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
            end
        end
    end

    // Compare process: every cycle out of reset the outputs must match the model
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cur_exp = mk(0, 0, 0, 0, 0, 0, 1);
        end else begin
            cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : mk(0, 0, 0, 0, 0, 0, 1);
            n_cmp++;
            if (wea !== cur_exp.wea || busy !== cur_exp.busy || done !== cur_exp.done ||
                cmd_err !== cur_exp.err || cmd_ready !== cur_exp.ready ||
                (cur_exp.wea && (addra !== cur_exp.addra || dina !== cur_exp.dina))) begin
                n_bad++;
                $display("FAIL cycle t=%0t got wea=%b addra=%0d dina=%h busy=%b done=%b err=%b ready=%b want wea=%b addra=%0d dina=%h busy=%b done=%b err=%b ready=%b",
                         $time, wea, addra, dina, busy, done, cmd_err, cmd_ready,
                         cur_exp.wea, cur_exp.addra, cur_exp.dina, cur_exp.busy, cur_exp.done, cur_exp.err, cur_exp.ready);
            end
            if (wea === 1'b1) wr_log.push_back(int'(addra));
        end
    end

    task automatic check_list(input string name, input int got[$], input int want[$]);
        bit ok;
        ok = (got.size() == want.size());
        if (ok) foreach (want[i]) if (got[i] != want[i]) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d entries (first %0d) want %0d entries (first %0d)", name,
                     got.size(), (got.size() != 0) ? got[0] : -1,
                     want.size(), (want.size() != 0) ? want[0] : -1);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic send(input bit fr, input int x0, input int y0, input int w, input int h,
                        input logic [31:0] col, input bit brd, input bit hold);
        int start, t;
        start = acc_cnt;
        t = 0;
        cmd_frame = fr; cmd_x0 = 7'(x0); cmd_y0 = 6'(y0);
        cmd_w = 7'(w); cmd_h = 6'(h); cmd_color = col;
`ifdef VRAM_FILL_BORDER_EN
        cmd_border = brd;
`else
        if (brd) $display("note: border request ignored in this build");
`endif
        cmd_valid = 1'b1;
        while (acc_cnt == start && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (acc_cnt == start) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no handshake want handshake within 3000 cycles");
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !cur_exp.ready || cur_exp.done) && t < 5000) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: got busy model want idle within 5000 cycles");
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int want[$];
        int pl[$];
        int n;

        repeat (3) @(negedge clk);
        #1;
        check_val("reset_outputs", int'({wea, busy, done, cmd_err}), 0);
        check_val("reset_addra", int'(addra), 0);
        check_val("reset_dina", int'(dina), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        #1 check_val("ready_after_reset", int'(cmd_ready), 1);
        @(negedge clk);

        // single cell, frame 0
        make_plan(0, 0, 0, 1, 1, 0, pl);
        want = '{2048};
        check_list("plan_1x1", pl, want);
        wr_log.delete();
        send(0, 0, 0, 1, 1, 32'hFFFF0000, 0, 0);
        wait_idle();
        check_list("dut_1x1", wr_log, want);

        // clipped at the bottom-right corner of frame 1
        make_plan(1, 78, 59, 5, 3, 0, pl);
        want = '{11646, 11647};
        check_list("plan_clip", pl, want);
        wr_log.delete();
        send(1, 78, 59, 5, 3, 32'h00000ABC, 0, 0);
        wait_idle();
        check_list("dut_clip", wr_log, want);

        // 3x2 block in the middle of frame 0
        make_plan(0, 10, 2, 3, 2, 0, pl);
        want = '{2218, 2219, 2220, 2298, 2299, 2300};
        check_list("plan_3x2", pl, want);
        wr_log.delete();
        send(0, 10, 2, 3, 2, 32'h12345678, 0, 0);
        wait_idle();
        check_list("dut_3x2", wr_log, want);

        // rejected commands
        want.delete();
        wr_log.delete();
        send(0, 80, 0, 4, 4, 32'h1, 0, 0);
        send(0, 5, 5, 0, 4, 32'h2, 0, 0);
        send(1, 5, 60, 4, 4, 32'h3, 0, 0);
        wait_idle();
        check_list("dut_rejects", wr_log, want);

        // second command held valid while the first is busy: 6 writes + done + ready cycle
        send(0, 10, 2, 3, 2, 32'hAAAA5555, 0, 1);
        send(1, 0, 0, 2, 1, 32'h5555AAAA, 0, 0);
        wait_idle();
        n = acc_cyc.size();
        check_val("held_accept_gap", acc_cyc[n-1] - acc_cyc[n-2], 8);

`ifdef VRAM_FILL_BORDER_EN
        make_plan(0, 0, 0, 3, 3, 1, pl);
        want = '{2048, 2049, 2050, 2128, 2130, 2208, 2209, 2210};
        check_list("plan_border", pl, want);
        wr_log.delete();
        send(0, 0, 0, 3, 3, 32'h00000F0F, 1, 0);
        wait_idle();
        check_list("dut_border", wr_log, want);
        for (int i = 0; i < 20; i++)
            send(1'($urandom_range(0, 1)), $urandom_range(0, 82), $urandom_range(0, 62),
                 $urandom_range(0, 9), $urandom_range(0, 7), $urandom, 1'b1, 0);
        wait_idle();
        cmd_border = 1'b0;
`endif

        // abort a long fill with reset
        send(0, 0, 0, 40, 10, 32'hDEADBEEF, 0, 0);
        repeat (20) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_val("abort_outputs", int'({wea, busy, done}), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check_val("ready_after_abort", int'(cmd_ready), 1);
        wr_log.delete();
        repeat (10) @(negedge clk);
        want.delete();
        check_list("no_writes_after_abort", wr_log, want);

        // randomized commands, some invalid, some back-to-back
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)), $urandom_range(0, 85), $urandom_range(0, 63),
                 $urandom_range(0, 20), $urandom_range(0, 10), $urandom, 1'b0,
                 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
